// File: rtl/lfsr_stream.sv
// -----------------------------------------------------------------------------
// lfsr_stream
//   Fibonacci LFSR pattern generator with a valid/ready output stream.
//   A seed arrives over a valid/ready port; a zero seed is replaced by
//   DEFAULT_SEED and flagged on the sticky lockup output. With STEPS > 1 the
//   register advances STEPS times per output beat, so beats are spaced
//   STEPS cycles apart.
//
//   Optional feature macro: LFSR_PERIOD_EN
//     defined   : period_count counts shifts since the last seed load
//                 (saturating) and period_hit pulses when the state returns
//                 to the last loaded seed.
//     undefined : the reference/counter logic is removed and both outputs
//                 are tied to zero.
// -----------------------------------------------------------------------------
module lfsr_stream #(
   parameter int unsigned      WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
   parameter int unsigned      STEPS        = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seed_valid,
   output logic             seed_ready,
   input  logic [WIDTH-1:0] seed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             lockup,
   output logic             period_hit,
   output logic [WIDTH-1:0] period_count
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ---------------------------------------------------------------------------
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_stream: WIDTH must be in 2..32");
   end
   if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_stream: STEPS must be in 1..WIDTH");
   end
   if (DEFAULT_SEED == '0) begin : g_bad_seed
      $error("lfsr_stream: DEFAULT_SEED must be non-zero");
   end

   // ---------------------------------------------------------------------------
   // Local types and constants
   // ---------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for the first seed
   localparam logic [1:0] ST_RUN  = 2'd1;  // beat presented on out_data
   localparam logic [1:0] ST_STEP = 2'd2;  // extra shifts between beats

   // Holds STEPS-1, the number of extra shifts after a beat transfer.
   localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   // One Fibonacci shift: parity of the tapped bits enters at bit 0.
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]        state_q,    state_d;
   logic [WIDTH-1:0]  lfsr_q,     lfsr_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic              lockup_q,   lockup_d;

   logic              seed_acc;    // seed handshake this cycle
   logic              xfer;        // output handshake this cycle
   logic              load_en;     // the register takes a seed this cycle
   logic              shift_en;    // the register shifts this cycle
   logic [WIDTH-1:0]  seed_val;    // seed after zero substitution
   logic [WIDTH-1:0]  lfsr_shift;  // register value after one shift

   // Handshake flags are pure functions of registered state, so the outputs
   // carry no combinational path from the inputs.
   assign seed_ready = (state_q != ST_STEP);
   assign out_valid  = (state_q == ST_RUN);
   assign out_data   = lfsr_q;
   assign lockup     = lockup_q;

   assign seed_acc   = seed_valid & seed_ready;
   assign xfer       = out_valid & out_ready;
   assign seed_val   = (seed == '0) ? DEFAULT_SEED : seed;
   assign lfsr_shift = lfsr_next(lfsr_q);

   // Next-state logic for the FSM, LFSR register, step counter and lockup flag.
   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves one unassigned; an unassigned path would infer a latch.
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      step_cnt_d = step_cnt_q;
      lockup_d   = lockup_q;
      load_en    = 1'b0;
      shift_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (seed_acc) begin
               load_en = 1'b1;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // A seed accepted in the same cycle as a transfer wins: the beat
            // leaves with the old value and the register takes the seed
            // instead of shifting.
            if (seed_acc) begin
               load_en = 1'b1;
            end else if (xfer) begin
               shift_en = 1'b1;
               if (STEPS > 1) begin
                  state_d    = ST_STEP;
                  step_cnt_d = STEP_W'(STEPS - 1);
               end
            end
         end

         ST_STEP: begin
            // One shift per cycle; the last one returns to RUN.
            shift_en = 1'b1;
            if (step_cnt_q <= STEP_W'(1)) begin
               step_cnt_d = '0;
               state_d    = ST_RUN;
            end else begin
               step_cnt_d = step_cnt_q - STEP_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load_en) begin
         lfsr_d = seed_val;
         if (seed == '0) begin
            lockup_d = 1'b1;
         end
      end else if (shift_en) begin
         lfsr_d = lfsr_shift;
      end
   end

   // Main state registers: asynchronous assert, released on the next edge.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this edge.
      if (reset) begin
         state_q    <= ST_IDLE;
         lfsr_q     <= DEFAULT_SEED;
         step_cnt_q <= '0;
         lockup_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         step_cnt_q <= step_cnt_d;
         lockup_q   <= lockup_d;
      end
   end

`ifdef LFSR_PERIOD_EN
   // ---------------------------------------------------------------------------
   // Period measurement against the last loaded seed
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] ref_seed_q,     ref_seed_d;
   logic [WIDTH-1:0] period_count_q, period_count_d;
   logic             period_hit_q,   period_hit_d;

   assign period_hit   = period_hit_q;
   assign period_count = period_count_q;

   // Reference capture, saturating shift count and return-to-seed detect.
   always_comb begin
      ref_seed_d     = ref_seed_q;
      period_count_d = period_count_q;
      // A load never coincides with a shift, so a hit is never raised by the
      // seed itself.
      period_hit_d   = shift_en && (lfsr_shift == ref_seed_q);

      if (load_en) begin
         ref_seed_d     = seed_val;
         period_count_d = '0;
      end else if (shift_en && (period_count_q != '1)) begin
         period_count_d = period_count_q + WIDTH'(1);
      end
   end

   // Period registers share the main reset so they match the reset seed.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the reference register is reset to DEFAULT_SEED, the value the
      // LFSR itself resets to, so the comparison is meaningful before any load.
      if (reset) begin
         ref_seed_q     <= DEFAULT_SEED;
         period_count_q <= '0;
         period_hit_q   <= 1'b0;
      end else begin
         ref_seed_q     <= ref_seed_d;
         period_count_q <= period_count_d;
         period_hit_q   <= period_hit_d;
      end
   end
`else
   // Period measurement disabled: constant outputs.
   logic unused_period;
   assign unused_period = load_en ^ shift_en;
   assign period_hit    = 1'b0;
   assign period_count  = '0;
`endif

   // ---------------------------------------------------------------------------
   // Protocol properties
   // ---------------------------------------------------------------------------
   // The seed path guarantees the register never reaches the all-zero lock state.
   a_never_zero : assert property (@(posedge clk) disable iff (reset)
      lfsr_q != '0);

   // A stalled beat must not change under backpressure.
   a_hold_stall : assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready && !seed_acc) |=> $stable(out_data) && out_valid);

   // Outside RUN no beat is offered.
   a_step_quiet : assert property (@(posedge clk) disable iff (reset)
      (state_q == ST_STEP) |-> (!out_valid && !seed_ready));

endmodule

// File: tb/tb_lfsr_stream.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream
//   Scoreboard bench for lfsr_stream (WIDTH=16, TAPS=B400, DEFAULT_SEED=ACE1).
//   Two instances: index 0 with STEPS=1 and index 1 with STEPS=4. Stimulus
//   pushes hand-computed beats into a per-instance queue; a monitor pops and
//   compares on every output handshake. Build with LFSR_PERIOD_EN to include
//   the full-period test.
// -----------------------------------------------------------------------------
module tb_lfsr_stream;

   logic              clk;
   logic              reset;
   logic [1:0]        seed_valid_v;
   logic [1:0]        seed_ready_v;
   logic [1:0][15:0]  seed_v;
   logic [1:0]        out_valid_v;
   logic [1:0]        out_ready_v;
   logic [1:0][15:0]  out_data_v;
   logic [1:0]        lockup_v;
   logic [1:0]        period_hit_v;
   logic [1:0][15:0]  period_count_v;

   logic [15:0] exp_q [2][$];
   logic [1:0]  mon_en;
   int          gap_cnt [2];
   int          tests_run;
   int          tests_failed;

   lfsr_stream #(.WIDTH(16), .TAPS(16'hB400), .DEFAULT_SEED(16'hACE1), .STEPS(1)) u_dut1 (
      .clk          (clk),
      .reset        (reset),
      .seed_valid   (seed_valid_v[0]),
      .seed_ready   (seed_ready_v[0]),
      .seed         (seed_v[0]),
      .out_valid    (out_valid_v[0]),
      .out_ready    (out_ready_v[0]),
      .out_data     (out_data_v[0]),
      .lockup       (lockup_v[0]),
      .period_hit   (period_hit_v[0]),
      .period_count (period_count_v[0])
   );

   lfsr_stream #(.WIDTH(16), .TAPS(16'hB400), .DEFAULT_SEED(16'hACE1), .STEPS(4)) u_dut4 (
      .clk          (clk),
      .reset        (reset),
      .seed_valid   (seed_valid_v[1]),
      .seed_ready   (seed_ready_v[1]),
      .seed         (seed_v[1]),
      .out_valid    (out_valid_v[1]),
      .out_ready    (out_ready_v[1]),
      .out_data     (out_data_v[1]),
      .lockup       (lockup_v[1]),
      .period_hit   (period_hit_v[1]),
      .period_count (period_count_v[1])
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare each handshaked beat with the scoreboard, count idle cycles.
   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            if (mon_en[d] && out_valid_v[d] && out_ready_v[d]) begin
               if (exp_q[d].size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("FAIL unexpected_beat_dut%0d: got %h expected none", d, out_data_v[d]);
               end else begin
                  check($sformatf("beat_dut%0d", d), 32'(out_data_v[d]), 32'(exp_q[d].pop_front()));
               end
            end
            if (out_ready_v[d] && !out_valid_v[d]) begin
               gap_cnt[d]++;
            end
         end
      end
   end

   // Offer a seed and hold it until the handshake completes (bounded).
   task automatic load_seed(input int d, input logic [15:0] v);
      bit seen = 1'b0;
      seed_v[d]       = v;
      seed_valid_v[d] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (seed_ready_v[d]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         tests_run++;
         tests_failed++;
         $display("FAIL seed_timeout_dut%0d: got seed_ready=0 expected 1", d);
      end
      @(posedge clk);
      #1;
      seed_valid_v[d] = 1'b0;
   endtask

   // Accept beats until the scoreboard queue drains (bounded), then stall.
   task automatic stream(input int d);
      out_ready_v[d] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (exp_q[d].size() == 0) break;
      end
      out_ready_v[d] = 1'b0;
      if (exp_q[d].size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL stream_timeout_dut%0d: got %0d beats left expected 0", d, exp_q[d].size());
         exp_q[d].delete();
      end
   endtask

   // Global watchdog.
   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog expired");
   end

   logic [15:0] vec1 [13];
   logic [15:0] vec3 [4];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      mon_en       = 2'b11;
      gap_cnt[0]   = 0;
      gap_cnt[1]   = 0;
      seed_valid_v = '0;
      seed_v       = '0;
      out_ready_v  = '0;
      vec1 = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
               16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801, 16'h1002};
      vec3 = '{16'h0001, 16'h0010, 16'h0100, 16'h1002};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state of both instances.
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_out_valid%0d", d),    32'(out_valid_v[d]),    32'd0);
         check($sformatf("rst_seed_ready%0d", d),   32'(seed_ready_v[d]),   32'd1);
         check($sformatf("rst_out_data%0d", d),     32'(out_data_v[d]),     32'hACE1);
         check($sformatf("rst_lockup%0d", d),       32'(lockup_v[d]),       32'd0);
         check($sformatf("rst_period_hit%0d", d),   32'(period_hit_v[d]),   32'd0);
         check($sformatf("rst_period_count%0d", d), 32'(period_count_v[d]), 32'd0);
      end

      // STEPS=1, seed 0001: back-to-back beats through the first feedback.
      load_seed(0, 16'h0001);
      check("run_out_valid", 32'(out_valid_v[0]), 32'd1);
      foreach (vec1[i]) exp_q[0].push_back(vec1[i]);
      gap_cnt[0] = 0;
      stream(0);
      check("steps1_gaps", 32'(gap_cnt[0]), 32'd0);
      check("steps1_after", 32'(out_data_v[0]), 32'h2005);
`ifdef LFSR_PERIOD_EN
      check("steps1_count", 32'(period_count_v[0]), 32'd13);
`else
      check("steps1_count", 32'(period_count_v[0]), 32'd0);
`endif

      // Zero seed substitution and sticky lockup.
      load_seed(0, 16'h0000);
      check("zero_lockup", 32'(lockup_v[0]), 32'd1);
      exp_q[0].push_back(16'hACE1);
      stream(0);
      load_seed(0, 16'h0005);
      exp_q[0].push_back(16'h0005);
      stream(0);
      check("lockup_sticky", 32'(lockup_v[0]), 32'd1);

      // Backpressure: 0005 shifted once gives 000A, which must hold.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_data", 32'(out_data_v[0]), 32'h000A);
      end
      @(posedge clk);
      #1;

      // Seed and transfer together: old beat leaves, next beat is the seed.
      exp_q[0].push_back(16'h000A);
      exp_q[0].push_back(16'h1234);
      seed_v[0]       = 16'h1234;
      seed_valid_v[0] = 1'b1;
      out_ready_v[0]  = 1'b1;
      @(posedge clk);
      #1;
      seed_valid_v[0] = 1'b0;
      stream(0);
      check("seed_xfer_after", 32'(out_data_v[0]), 32'h2469);
`ifdef LFSR_PERIOD_EN
      check("seed_xfer_count", 32'(period_count_v[0]), 32'd1);
`else
      check("seed_xfer_count", 32'(period_count_v[0]), 32'd0);
`endif

      // STEPS=4: beats every fourth shift with three idle cycles between.
      load_seed(1, 16'h0001);
      foreach (vec3[i]) exp_q[1].push_back(vec3[i]);
      gap_cnt[1] = 0;
      stream(1);
      check("steps4_gaps", 32'(gap_cnt[1]), 32'd9);
      check("steps4_mid_data", 32'(out_data_v[1]), 32'h2005);
      check("steps4_mid_valid", 32'(out_valid_v[1]), 32'd0);
      check("steps4_mid_seed_ready", 32'(seed_ready_v[1]), 32'd0);

      // Reset mid-STEP takes effect without a clock edge.
      reset = 1'b1;
      #1;
      check("rst_step_valid", 32'(out_valid_v[1]), 32'd0);
      check("rst_step_data", 32'(out_data_v[1]), 32'hACE1);
      check("rst_step_seed_ready", 32'(seed_ready_v[1]), 32'd1);
      check("rst_clears_lockup", 32'(lockup_v[0]), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_valid", 32'(out_valid_v[1]), 32'd0);

`ifdef LFSR_PERIOD_EN
      // Full period from seed 0001: one hit after 65535 shifts, count saturates.
      begin
         int n = 0;
         mon_en[0] = 1'b0;
         load_seed(0, 16'h0001);
         check("period_count_load", 32'(period_count_v[0]), 32'd0);
         out_ready_v[0] = 1'b1;
         for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (period_hit_v[0]) break;
         end
         check("period_shifts", 32'(n), 32'd65535);
         check("period_hit_data", 32'(out_data_v[0]), 32'h0001);
         check("period_count_full", 32'(period_count_v[0]), 32'hFFFF);
         @(posedge clk);
         #1;
         check("period_hit_pulse", 32'(period_hit_v[0]), 32'd0);
         check("period_count_sat", 32'(period_count_v[0]), 32'hFFFF);
         out_ready_v[0] = 1'b0;
         mon_en[0] = 1'b1;
      end
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
